// File: rtl/term_writer_if.sv
// ---------------------------------------------------------------------------
// term_writer_if
//   Bus bundle for the terminal character engine: the UART byte-stream
//   handshake on one side, the text RAM system write port and the cursor /
//   status outputs on the other.
//
//   Signals
//     rx_data  [7:0]        received byte
//     rx_valid              one-cycle strobe, rx_data valid
//     rx_ready              engine can accept a byte
//     ram_addr [ADDR_W-1:0] text RAM write address
//     ram_data [7:0]        text RAM write data
//     ram_wren              text RAM write enable
//     cursor_x [5:0]        current column
//     cursor_y [4:0]        current row
//     overrun               sticky dropped-byte flag
//
//   Modports
//     slave  : the engine (consumes bytes, drives RAM port and status)
//     master : the byte source / observer
//
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface term_writer_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_wren;
  logic [5:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic              overrun;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, ram_addr, ram_data, ram_wren, cursor_x, cursor_y, overrun
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, ram_addr, ram_data, ram_wren, cursor_x, cursor_y, overrun
  );
endinterface

`default_nettype wire

// File: rtl/term_writer.sv
// ---------------------------------------------------------------------------
// term_writer
//   Terminal character engine. Interprets bytes from the UART receiver
//   (printable, CR, LF, BS, FF), tracks a cursor and issues single-cycle
//   writes on the system port of the dual-port text RAM.
//
//   Ports
//     clk     system clock
//     resetn  asynchronous active-low reset
//     bus     term_writer_if.slave (byte handshake, RAM write port,
//             cursor position, overrun flag)
//
//   Optional feature
//     TERM_CLEAR_ON_RESET_EN : when defined, the screen is cleared
//     automatically after reset is released.
//
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module term_writer #(
  parameter int         COLS   = 40,
  parameter int         ROWS   = 15,
  parameter int         ADDR_W = 11,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  wire logic    clk,
  input  wire logic    resetn,
  term_writer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [5:0]        X_LAST = 6'(COLS - 1);
  localparam logic [4:0]        Y_LAST = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(COLS * ROWS - 1);

  logic [1:0]        state_q, state_d;
  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              ovr_q, ovr_d;

  logic              init_pending;
  logic              rx_ready;
  logic              accept;
  logic [ADDR_W-1:0] row_base;
  logic [5:0]        x_dec;

`ifdef TERM_CLEAR_ON_RESET_EN
  // Set by reset, consumed by the first IDLE cycle which launches a clear.
  logic init_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      init_q <= 1'b1;
    else if (state_q == S_IDLE)
      init_q <= 1'b0;
  end
  assign init_pending = init_q;
`else
  assign init_pending = 1'b0;
`endif

  // While reset is held the engine reads as ready; once released with a
  // pending power-on clear it must refuse bytes until that clear finishes.
  assign rx_ready = (state_q == S_IDLE) && !(init_pending && resetn);
  assign accept   = bus.rx_valid && rx_ready;

  // Constant multiply; the tools reduce it to shift-add.
  assign row_base = ADDR_W'(y_q) * A_COLS;
  assign x_dec    = x_q - 6'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    ovr_d   = ovr_q | (bus.rx_valid & ~rx_ready);

    case (state_q)
      S_IDLE: begin
        if (init_pending) begin
          state_d = S_CLEAR;
          wren_d  = 1'b1;
          addr_d  = '0;
          data_d  = BLANK;
        end else if (accept) begin
          if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
            state_d = S_WRITE;
            wren_d  = 1'b1;
            addr_d  = row_base + ADDR_W'(x_q);
            data_d  = bus.rx_data;
            // Advance with wrap; the screen never scrolls.
            if (x_q == X_LAST) begin
              x_d = 6'd0;
              y_d = (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
            end else begin
              x_d = x_q + 6'd1;
            end
          end else begin
            case (bus.rx_data)
              8'h0D: x_d = 6'd0;
              8'h0A: y_d = (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
              8'h08: begin
                if (x_q != 6'd0) begin
                  state_d = S_WRITE;
                  x_d     = x_dec;
                  wren_d  = 1'b1;
                  addr_d  = row_base + ADDR_W'(x_dec);
                  data_d  = BLANK;
                end
              end
              8'h0C: begin
                state_d = S_CLEAR;
                wren_d  = 1'b1;
                addr_d  = '0;
                data_d  = BLANK;
              end
              default: ;
            endcase
          end
        end
      end

      S_WRITE: state_d = S_IDLE;

      // ram_addr doubles as the clear counter.
      S_CLEAR: begin
        if (addr_q == A_LAST) begin
          state_d = S_IDLE;
          x_d     = 6'd0;
          y_d     = 5'd0;
        end else begin
          wren_d = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= 6'd0;
      y_q     <= 5'd0;
      addr_q  <= '0;
      data_q  <= 8'd0;
      wren_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_wren = wren_q;
  assign bus.cursor_x = x_q;
  assign bus.cursor_y = y_q;
  assign bus.overrun  = ovr_q;

endmodule

`default_nettype wire

// File: doc/term_writer.md
Name: term_writer

Overview:
- Terminal character engine between the UART receiver byte stream and the dual-port text RAM used by the video path.
- Interprets received bytes (printable, CR, LF, BS, FF), tracks a cursor, and issues single-cycle writes on the text RAM system port.
- Runs in the system (UART) clock domain.

Parameters:
COLS, 40, characters per row
ROWS, 15, rows on screen
ADDR_W, 11, text RAM address width; COLS*ROWS <= 2**ADDR_W required
BLANK, 8'h20, fill character for clear and backspace

Ports:
clk  input  1  system clock
resetn  input  1  reset; asynchronous, active-low
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_ready  output  1  high when a byte can be accepted
ram_addr  output  ADDR_W  text RAM write address
ram_data  output  8  text RAM write data
ram_wren  output  1  text RAM write enable, one cycle per write
cursor_x  output  6  current column, 0..COLS-1
cursor_y  output  5  current row, 0..ROWS-1
overrun  output  1  sticky: byte arrived while not ready

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; rx_ready=1; ram_wren=0; ram_addr=0; ram_data=0; cursor_x=0; cursor_y=0; overrun=0.
- Accept: rx_valid && rx_ready in cycle N.
- States: IDLE, WRITE, CLEAR.
- IDLE, printable byte 0x20..0x7E:
  - cycle N+1: state WRITE, ram_wren=1, ram_addr=cursor_y*COLS+cursor_x (pre-advance), ram_data=rx_data, rx_ready=0.
  - Cursor advances in N+1: x+1; if x==COLS-1 then x=0, y+1; if also y==ROWS-1 then y=0 (wrap, no scroll).
  - cycle N+2: back to IDLE, ram_wren=0, rx_ready=1. Maximum rate: one printable byte per 2 cycles.
- CR 0x0D: x=0 in N+1. No write. Stays IDLE; rx_ready stays 1.
- LF 0x0A: y+1 in N+1, wrapping ROWS-1 to 0; x unchanged. No write.
- BS 0x08:
  - If x>0: x-1, then a write of BLANK at the new position, with the same timing as a printable byte (goes through WRITE).
  - If x==0: no action.
- FF 0x0C: cycle N+1 enters CLEAR with rx_ready=0.
  - CLEAR writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, with ram_wren high for exactly COLS*ROWS consecutive cycles.
  - The cycle after the last write: IDLE, cursor (0,0), rx_ready=1.
- All other bytes (0x00..0x1F not listed above, 0x7F..0xFF): ignored, no state change.
- rx_valid while rx_ready=0: byte dropped; overrun=1 from the next cycle until reset.
- Address arithmetic is done at ADDR_W width; y*COLS uses a constant multiply (shift-add permitted).
- Reset mid-CLEAR or mid-WRITE: immediate return to reset values; a partial clear is not resumed.
- ram_addr and ram_data hold their last values when ram_wren=0.

Optional Feature:
- Macro: TERM_CLEAR_ON_RESET_EN
- Defined: after resetn deasserts, the block enters CLEAR automatically (rx_ready=0), writes COLS*ROWS blanks, then goes to IDLE. Bytes arriving during this clear set overrun.
- Not defined: the block starts in IDLE with rx_ready=1 and no writes. RAM initial contents are the RAM's own responsibility.

Test Plan:
- Reset then send 0x41 -> one cycle later ram_wren=1, ram_addr=0, ram_data=0x41; cursor (1,0); rx_ready low 1 cycle.
- Send 40 printable bytes, then 0x42 -> 40th write at ram_addr=39, cursor (0,1); 0x42 written at ram_addr=40.
- Send "AB", 0x08, 0x0D, 0x0A at (0,0) -> BLANK written at addr 1, cursor (1,0); after CR (0,0); after LF (0,1). A second 0x08 at x=0 produces no write.
- At cursor (5,14) send 0x0A -> cursor (5,0), no write.
- Send 0x0C -> 600 consecutive writes of 0x20 at addr 0..599; rx_ready=0 for 600 cycles; then cursor (0,0). A byte injected mid-clear sets overrun=1.
- Assert resetn low at clear write 300 -> outputs at reset values immediately; no further writes after release (macro undefined). With the macro defined, a 600-write clear follows release.
